// File: rtl/hx8352_init_seq.sv
// Power-up sequencer for the HX8352 LCD controller: walks an init table, issuing bus
// writes for CMD/DATA entries and ms delays for DELAY entries until an END entry.
module hx8352_init_seq #(
    parameter int ROM_AW   = 6,
    parameter int STEP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [17:0]       rom_data,
    output logic              wr_req,
    output logic              wr_rs,
    output logic [15:0]       wr_data,
    input  logic              wr_ack,
    output logic [7:0]        delay_ms,
    output logic              delay_step,
    input  logic              delay_done,
    output logic              busy,
    output logic              init_done,
    output logic              err
);

    localparam int                SCW       = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [SCW-1:0]    STEP_LAST = SCW'(STEP_CYC - 1);
    localparam logic [ROM_AW-1:0] LAST_ADDR = '1;

    localparam logic [1:0] T_CMD   = 2'b00;
    localparam logic [1:0] T_DATA  = 2'b01;
    localparam logic [1:0] T_DELAY = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_DLY_STEP,
        S_DLY_ARM,
        S_DLY_WAIT,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              wr_req_q, wr_req_d;
    logic              wr_rs_q, wr_rs_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic [7:0]        delay_ms_q, delay_ms_d;
    logic              delay_step_q, delay_step_d;
    logic [SCW-1:0]    step_cnt_q, step_cnt_d;
    logic              busy_q, busy_d;
    logic              init_done_q, init_done_d;
    logic              err_q, err_d;
    logic              start_q;
    logic              start_edge;

    assign start_edge = start & ~start_q;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch.
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        wr_req_d     = wr_req_q;
        wr_rs_d      = wr_rs_q;
        wr_data_d    = wr_data_q;
        delay_ms_d   = delay_ms_q;
        delay_step_d = delay_step_q;
        step_cnt_d   = step_cnt_q;
        busy_d       = busy_q;
        init_done_d  = init_done_q;
        err_d        = err_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_edge) begin
                    state_d     = S_FETCH;
                    rom_addr_d  = '0;
                    busy_d      = 1'b1;
                    init_done_d = 1'b0;
                    err_d       = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                unique case (rom_data[17:16])
                    T_CMD, T_DATA: begin
                        wr_rs_d   = rom_data[16];
                        wr_data_d = rom_data[15:0];
                        wr_req_d  = 1'b1;
                        state_d   = S_WRITE;
                    end
                    T_DELAY: begin
                        delay_ms_d   = rom_data[7:0];
                        delay_step_d = 1'b1;
                        step_cnt_d   = '0;
                        state_d      = S_DLY_STEP;
                    end
                    default: begin
                        busy_d      = 1'b0;
                        init_done_d = 1'b1;
                        state_d     = S_DONE;
                    end
                endcase
            end
            S_WRITE: begin
                // wr_req is high for the whole of WRITE, so a first-cycle ack is honoured.
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    state_d  = S_NEXT;
                end
            end
            S_DLY_STEP: begin
                if (step_cnt_q == STEP_LAST) begin
                    delay_step_d = 1'b0;
                    state_d      = S_DLY_ARM;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            S_DLY_ARM:  if (!delay_done) state_d = S_DLY_WAIT;
            S_DLY_WAIT: if (delay_done)  state_d = S_NEXT;
            S_NEXT: begin
                if (rom_addr_q == LAST_ADDR) begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= '0;
            wr_req_q     <= 1'b0;
            wr_rs_q      <= 1'b0;
            wr_data_q    <= '0;
            delay_ms_q   <= '0;
            delay_step_q <= 1'b0;
            step_cnt_q   <= '0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            wr_req_q     <= wr_req_d;
            wr_rs_q      <= wr_rs_d;
            wr_data_q    <= wr_data_d;
            delay_ms_q   <= delay_ms_d;
            delay_step_q <= delay_step_d;
            step_cnt_q   <= step_cnt_d;
            busy_q       <= busy_d;
            init_done_q  <= init_done_d;
            err_q        <= err_d;
            start_q      <= start;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign wr_req     = wr_req_q;
    assign wr_rs      = wr_rs_q;
    assign wr_data    = wr_data_q;
    assign delay_ms   = delay_ms_q;
    assign delay_step = delay_step_q;
    assign busy       = busy_q;
    assign init_done  = init_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_hx8352_init_seq.sv
// Directed bench for hx8352_init_seq with a registered ROM, an LCD writer model with a
// programmable ack latency, and a delay block model (4 clock cycles per ms).
module tb_hx8352_init_seq;

    localparam logic [1:0] T_CMD   = 2'b00;
    localparam logic [1:0] T_DATA  = 2'b01;
    localparam logic [1:0] T_DELAY = 2'b10;
    localparam logic [1:0] T_END   = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  rom_addr;
    logic [17:0] rom_data;
    logic        wr_req;
    logic        wr_rs;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic [7:0]  delay_ms;
    logic        delay_step;
    logic        delay_done;
    logic        busy;
    logic        init_done;
    logic        err;

    int total = 0;
    int bad   = 0;

    hx8352_init_seq #(.ROM_AW(6), .STEP_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .wr_req     (wr_req),
        .wr_rs      (wr_rs),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .delay_ms   (delay_ms),
        .delay_step (delay_step),
        .delay_done (delay_done),
        .busy       (busy),
        .init_done  (init_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    logic [17:0] rom [64];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Writer model: ack once wr_req has been high for ack_wait full cycles.
    int ack_wait = 1;
    int req_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 req_cnt <= 0;
        else if (!wr_req || wr_ack) req_cnt <= 0;
        else                        req_cnt <= req_cnt + 1;
    end
    assign wr_ack = wr_req && (req_cnt >= ack_wait);

    logic [16:0] wr_log [$];
    always @(posedge clk) if (wr_req && wr_ack) wr_log.push_back({wr_rs, wr_data});

    // Delay model: done low for delay_ms*4+1 cycles after the last step cycle.
    int dly_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            dly_cnt <= 0;
        else if (delay_step)   dly_cnt <= int'(delay_ms) * 4 + 1;
        else if (dly_cnt != 0) dly_cnt <= dly_cnt - 1;
    end
    assign delay_done = (dly_cnt == 0);

    int         step_hi      = 0;
    int         req_in_delay = 0;
    logic [7:0] ms_at_step   = '0;
    always @(posedge clk) begin
        if (delay_step) begin
            step_hi    <= step_hi + 1;
            ms_at_step <= delay_ms;
        end
        if (wr_req && !delay_done) req_in_delay <= req_in_delay + 1;
    end

    task automatic rom_clear();
        for (int i = 0; i < 64; i++) rom[i] = {T_END, 16'h0000};
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL %s: timeout, busy=%0b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rom_clear();
        repeat (3) @(negedge clk);
        total++;
        if ({rom_addr, wr_req, wr_rs, wr_data, delay_ms, delay_step, busy, init_done, err} !== '0) begin
            bad++;
            $display("FAIL reset_in: outputs=%h required 0",
                     {rom_addr, wr_req, wr_rs, wr_data, delay_ms, delay_step, busy, init_done, err});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({rom_addr, wr_req, wr_rs, wr_data, delay_ms, delay_step, busy, init_done, err} !== '0) begin
            bad++;
            $display("FAIL reset_idle: outputs=%h required 0",
                     {rom_addr, wr_req, wr_rs, wr_data, delay_ms, delay_step, busy, init_done, err});
        end
    endtask

    task automatic test_cmd_data();
        int base = wr_log.size();
        rom_clear();
        rom[0] = {T_CMD, 16'h0083};
        rom[1] = {T_DATA, 16'h0002};
        ack_wait = 1;
        pulse_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL t1_busy: busy=%0b required 1", busy);
        end
        wait_done("t1_done", 100);
        total++;
        if (wr_log.size() - base != 2) begin
            bad++;
            $display("FAIL t1_count: writes=%0d required 2", wr_log.size() - base);
        end else begin
            total++;
            if (wr_log[base] !== {1'b0, 16'h0083} || wr_log[base+1] !== {1'b1, 16'h0002}) begin
                bad++;
                $display("FAIL t1_words: got %h,%h required 00083,10002", wr_log[base], wr_log[base+1]);
            end
        end
        total++;
        if ({init_done, busy, err} !== 3'b100) begin
            bad++;
            $display("FAIL t1_flags: done/busy/err=%b required 100", {init_done, busy, err});
        end
    endtask

    task automatic test_delay();
        int base  = wr_log.size();
        int sbase = step_hi;
        int rbase = req_in_delay;
        rom_clear();
        rom[0] = {T_DELAY, 16'hAB05};
        rom[1] = {T_CMD, 16'h0022};
        ack_wait = 0;
        pulse_start();
        wait_done("t2_done", 200);
        total++;
        if (step_hi - sbase != 2) begin
            bad++;
            $display("FAIL t2_step: step cycles=%0d required 2", step_hi - sbase);
        end
        total++;
        if (ms_at_step !== 8'd5 || delay_ms !== 8'd5) begin
            bad++;
            $display("FAIL t2_ms: delay_ms=%0d/%0d required 5", ms_at_step, delay_ms);
        end
        total++;
        if (req_in_delay != rbase) begin
            bad++;
            $display("FAIL t2_early_req: wr_req cycles during delay=%0d required 0", req_in_delay - rbase);
        end
        total++;
        if (wr_log.size() - base != 1 || wr_log[base] !== {1'b0, 16'h0022}) begin
            bad++;
            $display("FAIL t2_write: writes=%0d required 1 of 00022", wr_log.size() - base);
        end
        total++;
        if (init_done !== 1'b1) begin
            bad++;
            $display("FAIL t2_init_done: init_done=%0b required 1", init_done);
        end
    endtask

    task automatic test_ack_stall();
        int base = wr_log.size();
        int n    = 0;
        rom_clear();
        rom[0] = {T_CMD, 16'h00FF};
        ack_wait = 20;
        pulse_start();
        while (!wr_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (wr_req !== 1'b1 || wr_data !== 16'h00FF || wr_rs !== 1'b0) begin
                bad++;
                $display("FAIL t3_hold[%0d]: req=%0b rs=%0b data=%h required 1,0,00ff",
                         i, wr_req, wr_rs, wr_data);
            end
        end
        wait_done("t3_done", 100);
        total++;
        if (wr_log.size() - base != 1) begin
            bad++;
            $display("FAIL t3_count: writes=%0d required 1", wr_log.size() - base);
        end
    endtask

    task automatic test_overrun();
        int base = wr_log.size();
        for (int i = 0; i < 64; i++) rom[i] = {T_CMD, 16'h0100 + 16'(i)};
        ack_wait = 0;
        pulse_start();
        wait_done("t4_done", 400);
        total++;
        if (wr_log.size() - base != 64) begin
            bad++;
            $display("FAIL t4_count: writes=%0d required 64", wr_log.size() - base);
        end else begin
            total++;
            if (wr_log[base] !== {1'b0, 16'h0100} || wr_log[base+63] !== {1'b0, 16'h013F}) begin
                bad++;
                $display("FAIL t4_words: first=%h last=%h required 00100,0013f",
                         wr_log[base], wr_log[base+63]);
            end
        end
        total++;
        if ({err, init_done, busy} !== 3'b100 || rom_addr !== 6'd63) begin
            bad++;
            $display("FAIL t4_err: err/done/busy=%b addr=%0d required 100, 63",
                     {err, init_done, busy}, rom_addr);
        end
    endtask

    task automatic test_reset_mid_delay();
        int base;
        int sbase;
        rom_clear();
        rom[0] = {T_DELAY, 16'h0032};
        rom[1] = {T_CMD, 16'h0011};
        ack_wait = 1;
        pulse_start();
        repeat (15) @(negedge clk);
        total++;
        if (delay_done !== 1'b0 || busy !== 1'b1 || delay_ms !== 8'd50) begin
            bad++;
            $display("FAIL t5_in_delay: done=%0b busy=%0b ms=%0d required 0,1,50", delay_done, busy, delay_ms);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rom_addr, wr_req, wr_rs, wr_data, delay_ms, delay_step, busy, init_done, err} !== '0) begin
            bad++;
            $display("FAIL t5_async: outputs=%h required 0",
                     {rom_addr, wr_req, wr_rs, wr_data, delay_ms, delay_step, busy, init_done, err});
        end
        @(negedge clk) rst_n = 1'b1;
        base  = wr_log.size();
        sbase = step_hi;
        pulse_start();
        wait_done("t5_done", 400);
        total++;
        if (step_hi - sbase != 2 || wr_log.size() - base != 1 || wr_log[base] !== {1'b0, 16'h0011}) begin
            bad++;
            $display("FAIL t5_replay: steps=%0d writes=%0d required 2 steps, 1 write of 00011",
                     step_hi - sbase, wr_log.size() - base);
        end
        total++;
        if (init_done !== 1'b1) begin
            bad++;
            $display("FAIL t5_init_done: init_done=%0b required 1", init_done);
        end
    endtask

    task automatic test_back_to_back();
        int base = wr_log.size();
        rom_clear();
        rom[0] = {T_CMD, 16'h0083};
        rom[1] = {T_DATA, 16'h0002};
        ack_wait = 3;
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_done("t6_first", 100);
        total++;
        if (wr_log.size() - base != 2 || init_done !== 1'b1) begin
            bad++;
            $display("FAIL t6_ignore: writes=%0d done=%0b required 2,1", wr_log.size() - base, init_done);
        end
        base = wr_log.size();
        pulse_start();
        total++;
        if (init_done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL t6_restart: done=%0b busy=%0b required 0,1", init_done, busy);
        end
        wait_done("t6_second", 100);
        total++;
        if (wr_log.size() - base != 2 || wr_log[base] !== {1'b0, 16'h0083} || init_done !== 1'b1) begin
            bad++;
            $display("FAIL t6_replay: writes=%0d done=%0b required 2 from 00083, 1",
                     wr_log.size() - base, init_done);
        end
    endtask

    initial begin
        test_reset();
        test_cmd_data();
        test_delay();
        test_ack_stall();
        test_overrun();
        test_reset_mid_delay();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
